// File: rtl/blit_rect_fill.sv
// Rectangle-fill engine: clips a fill command against a clip window and emits one
// byte-enabled 32-bit write per touched word. Optional `BLIT_RECT_DITHER_EN` adds checkerboard dither.
module blit_rect_fill #(
  parameter int BPP    = 8,
  parameter int ADDR_W = 26
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_dest_addr,
  input  logic [15:0]       cmd_bpl,
  input  logic [15:0]       cmd_x1,
  input  logic [15:0]       cmd_y1,
  input  logic [15:0]       cmd_x2,
  input  logic [15:0]       cmd_y2,
  input  logic [15:0]       clip_x1,
  input  logic [15:0]       clip_y1,
  input  logic [15:0]       clip_x2,
  input  logic [15:0]       clip_y2,
  input  logic [31:0]       cmd_color,
  input  logic [31:0]       cmd_color2,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_byte_enable,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done
);
  localparam int BB  = BPP / 8;
  localparam int PPW = 32 / BPP;

  typedef enum logic [1:0] {IDLE, SETUP, WRITE, GAP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] dest_q, dest_d, row_q, row_d;
  logic [15:0]       bpl_q, bpl_d;
  logic [15:0]       x1_q, x1_d, x2_q, x2_d, y1_q, y1_d, y2_q, y2_d;
  logic [15:0]       kx1_q, kx1_d, kx2_q, kx2_d, ky1_q, ky1_d, ky2_q, ky2_d;
  logic [15:0]       cx1_q, cx1_d, cx2_q, cx2_d, cy2_q, cy2_d, x_q, x_d, y_q, y_d;
  logic [31:0]       color_q, color_d, color2_q, color2_d;
  logic              mem_req_q, mem_req_d, done_q, done_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;

  // Clipped window, word generator inputs and outputs
  logic [15:0]       cx1c, cx2c, cy1c, cy2c;
  logic [ADDR_W-1:0] g_row, g_byte;
  logic [15:0]       g_x, g_y, g_cx2;
  logic [16:0]       g_xb, g_end, g_lim, px;
  logic [3:0]        g_be;
  logic [31:0]       g_data;
  logic [BPP-1:0]    pcol;

  always_comb begin
    cx1c = (x1_q > kx1_q) ? x1_q : kx1_q;
    cy1c = (y1_q > ky1_q) ? y1_q : ky1_q;
    cx2c = (x2_q < kx2_q) ? x2_q : kx2_q;
    cy2c = (y2_q < ky2_q) ? y2_q : ky2_q;

    // SETUP produces the first word straight from the freshly clipped window.
    if (state_q == SETUP) begin
      g_row = dest_q + ADDR_W'(cy1c) * ADDR_W'(bpl_q);
      g_x   = cx1c;
      g_y   = cy1c;
      g_cx2 = cx2c;
    end else begin
      g_row = row_q;
      g_x   = x_q;
      g_y   = y_q;
      g_cx2 = cx2_q;
    end

    g_xb   = {1'b0, g_x & ~16'(PPW - 1)};
    g_end  = g_xb + 17'(PPW);
    g_lim  = (g_end < {1'b0, g_cx2}) ? g_end : {1'b0, g_cx2};
    g_byte = g_row + ADDR_W'(g_x) * ADDR_W'(BB);
    g_be   = '0;
    g_data = '0;
    px     = '0;
    pcol   = '0;
    for (int p = 0; p < PPW; p++) begin
      px = g_xb + 17'(p);
`ifdef BLIT_RECT_DITHER_EN
      pcol = (px[0] ^ g_y[0]) ? color2_q[BPP-1:0] : color_q[BPP-1:0];
`else
      pcol = color_q[BPP-1:0];
`endif
      g_data[p*BPP +: BPP] = pcol;
      g_be[p*BB +: BB]     = {BB{(px >= {1'b0, g_x}) && (px < g_lim)}};
    end

    state_d = state_q;   dest_d = dest_q;     row_d = row_q;       bpl_d = bpl_q;
    x1_d = x1_q;         x2_d = x2_q;         y1_d = y1_q;         y2_d = y2_q;
    kx1_d = kx1_q;       kx2_d = kx2_q;       ky1_d = ky1_q;       ky2_d = ky2_q;
    cx1_d = cx1_q;       cx2_d = cx2_q;       cy2_d = cy2_q;       x_d = x_q;
    y_d = y_q;           color_d = color_q;   color2_d = color2_q;
    mem_req_d = mem_req_q;   mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;   mem_be_d = mem_be_q;
    done_d = 1'b0;

    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d = SETUP;   dest_d = cmd_dest_addr;   bpl_d = cmd_bpl;
        x1_d = cmd_x1;     x2_d = cmd_x2;     y1_d = cmd_y1;     y2_d = cmd_y2;
        kx1_d = clip_x1;   kx2_d = clip_x2;   ky1_d = clip_y1;   ky2_d = clip_y2;
        color_d = cmd_color;   color2_d = cmd_color2;
      end
      SETUP: if (cx1c >= cx2c || cy1c >= cy2c) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        row_d = g_row;   x_d = cx1c;   y_d = cy1c;
        cx1_d = cx1c;    cx2_d = cx2c; cy2_d = cy2c;
        mem_addr_d  = {g_byte[ADDR_W-1:2], 2'b00};
        mem_wdata_d = g_data;
        mem_be_d    = g_be;
        mem_req_d   = 1'b1;
        state_d     = WRITE;
      end
      WRITE: if (mem_ack) begin
        mem_req_d = 1'b0;
        if (g_end >= {1'b0, cx2_q}) begin
          if (y_q + 16'd1 == cy2_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            y_d     = y_q + 16'd1;
            row_d   = row_q + ADDR_W'(bpl_q);
            x_d     = cx1_q;
            state_d = GAP;
          end
        end else begin
          x_d     = g_end[15:0];
          state_d = GAP;
        end
      end
      GAP: begin
        mem_addr_d  = {g_byte[ADDR_W-1:2], 2'b00};
        mem_wdata_d = g_data;
        mem_be_d    = g_be;
        mem_req_d   = 1'b1;
        state_d     = WRITE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;   dest_q <= '0;   row_q <= '0;   bpl_q <= '0;
      x1_q <= '0;    x2_q <= '0;    y1_q <= '0;    y2_q <= '0;
      kx1_q <= '0;   kx2_q <= '0;   ky1_q <= '0;   ky2_q <= '0;
      cx1_q <= '0;   cx2_q <= '0;   cy2_q <= '0;   x_q <= '0;   y_q <= '0;
      color_q <= '0;   color2_q <= '0;
      mem_req_q <= 1'b0;   mem_addr_q <= '0;   mem_wdata_q <= '0;   mem_be_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;   dest_q <= dest_d;   row_q <= row_d;   bpl_q <= bpl_d;
      x1_q <= x1_d;    x2_q <= x2_d;    y1_q <= y1_d;    y2_q <= y2_d;
      kx1_q <= kx1_d;  kx2_q <= kx2_d;  ky1_q <= ky1_d;  ky2_q <= ky2_d;
      cx1_q <= cx1_d;  cx2_q <= cx2_d;  cy2_q <= cy2_d;  x_q <= x_d;   y_q <= y_d;
      color_q <= color_d;   color2_q <= color2_d;
      mem_req_q <= mem_req_d;   mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;   mem_be_q <= mem_be_d;
      done_q <= done_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{color_q, color2_q, g_y, g_byte[1:0]};

  assign cmd_ready       = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign mem_req         = mem_req_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_byte_enable = mem_be_q;
  assign done            = done_q;
endmodule

// File: tb/tb_blit_rect_fill.sv
// Directed bench for blit_rect_fill: BPP=8 and BPP=16 instances, expected writes
// queued per command and popped by per-instance monitors on each accepted request.
module tb_blit_rect_fill;
  localparam int AW = 26;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] cmd_dest_addr = '0;
  logic [15:0]   cmd_bpl = '0, cmd_x1 = '0, cmd_y1 = '0, cmd_x2 = '0, cmd_y2 = '0;
  logic [15:0]   clip_x1 = '0, clip_y1 = '0, clip_x2 = '0, clip_y2 = '0;
  logic [31:0]   cmd_color = '0, cmd_color2 = '0;

  logic          cmd_valid8 = 1'b0, cmd_ready8, mem_req8, mem_ack8 = 1'b0, busy8, done8;
  logic [AW-1:0] mem_addr8;
  logic [31:0]   mem_wdata8;
  logic [3:0]    mem_be8;
  logic          cmd_valid16 = 1'b0, cmd_ready16, mem_req16, mem_ack16 = 1'b0, busy16, done16;
  logic [AW-1:0] mem_addr16;
  logic [31:0]   mem_wdata16;
  logic [3:0]    mem_be16;

  logic          stall8 = 1'b0;
  logic [61:0]   exp8_q[$];
  logic [61:0]   exp16_q[$];
  int            n_cmp = 0, n_bad = 0, done_cnt8 = 0, done_cnt16 = 0;
  logic          prev_hs8 = 1'b0, prev_hs16 = 1'b0;

  always #5 clock = ~clock;

  blit_rect_fill #(.BPP(8), .ADDR_W(AW)) u8 (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid8), .cmd_ready(cmd_ready8),
    .cmd_dest_addr(cmd_dest_addr), .cmd_bpl(cmd_bpl), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_x2(cmd_x2), .cmd_y2(cmd_y2), .clip_x1(clip_x1), .clip_y1(clip_y1),
    .clip_x2(clip_x2), .clip_y2(clip_y2), .cmd_color(cmd_color), .cmd_color2(cmd_color2),
    .mem_req(mem_req8), .mem_addr(mem_addr8), .mem_wdata(mem_wdata8),
    .mem_byte_enable(mem_be8), .mem_ack(mem_ack8), .busy(busy8), .done(done8));

  blit_rect_fill #(.BPP(16), .ADDR_W(AW)) u16 (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid16), .cmd_ready(cmd_ready16),
    .cmd_dest_addr(cmd_dest_addr), .cmd_bpl(cmd_bpl), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_x2(cmd_x2), .cmd_y2(cmd_y2), .clip_x1(clip_x1), .clip_y1(clip_y1),
    .clip_x2(clip_x2), .clip_y2(clip_y2), .cmd_color(cmd_color), .cmd_color2(cmd_color2),
    .mem_req(mem_req16), .mem_addr(mem_addr16), .mem_wdata(mem_wdata16),
    .mem_byte_enable(mem_be16), .mem_ack(mem_ack16), .busy(busy16), .done(done16));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [61:0] ex(input logic [AW-1:0] a, input logic [3:0] be,
                                     input logic [31:0] d);
    return {a, be, d};
  endfunction

  // Monitors: acks are driven on the falling edge, accepted writes are checked 1ns later.
  always @(negedge clock) begin
    logic [61:0] e;
    mem_ack8 = mem_req8 && !stall8;
    #1;
    if (prev_hs8) check("gap8", {63'd0, mem_req8}, 64'd0);
    prev_hs8 = 1'b0;
    if (mem_req8 && mem_ack8) begin
      prev_hs8 = 1'b1;
      if (exp8_q.size() == 0) begin
        check("unexpected_write8", {38'd0, mem_addr8}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp8_q.pop_front();
        check("addr8", {38'd0, mem_addr8}, {38'd0, e[61:36]});
        check("be8",   {60'd0, mem_be8},   {60'd0, e[35:32]});
        check("data8", {32'd0, mem_wdata8}, {32'd0, e[31:0]});
      end
    end
    if (done8) done_cnt8++;
  end

  always @(negedge clock) begin
    logic [61:0] e;
    mem_ack16 = mem_req16;
    #1;
    if (prev_hs16) check("gap16", {63'd0, mem_req16}, 64'd0);
    prev_hs16 = 1'b0;
    if (mem_req16 && mem_ack16) begin
      prev_hs16 = 1'b1;
      if (exp16_q.size() == 0) begin
        check("unexpected_write16", {38'd0, mem_addr16}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp16_q.pop_front();
        check("addr16", {38'd0, mem_addr16}, {38'd0, e[61:36]});
        check("be16",   {60'd0, mem_be16},   {60'd0, e[35:32]});
        check("data16", {32'd0, mem_wdata16}, {32'd0, e[31:0]});
      end
    end
    if (done16) done_cnt16++;
  end

  task automatic set_cmd(input logic [AW-1:0] dest, input logic [15:0] bpl,
                         input logic [15:0] x1, y1, x2, y2, kx1, ky1, kx2, ky2,
                         input logic [31:0] c1, c2);
    cmd_dest_addr = dest; cmd_bpl = bpl;
    cmd_x1 = x1; cmd_y1 = y1; cmd_x2 = x2; cmd_y2 = y2;
    clip_x1 = kx1; clip_y1 = ky1; clip_x2 = kx2; clip_y2 = ky2;
    cmd_color = c1; cmd_color2 = c2;
  endtask

  // Presents the current command; returns 1ns after the accepting edge.
  task automatic send(input bit sel16);
    bit ok = 1'b0;
    @(negedge clock);
    if (sel16) cmd_valid16 = 1'b1; else cmd_valid8 = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock);
      if (sel16 ? cmd_ready16 : cmd_ready8) begin ok = 1'b1; break; end
    end
    #1;
    cmd_valid8 = 1'b0;
    cmd_valid16 = 1'b0;
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle(input bit sel16);
    bit ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      #2;
      if (sel16 ? (!busy16 && exp16_q.size() == 0) : (!busy8 && exp8_q.size() == 0)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    logic [31:0] dith_exp;
`ifdef BLIT_RECT_DITHER_EN
    dith_exp = 32'h2211_2211;
`else
    dith_exp = 32'h1111_1111;
`endif
    #2;
    check("rst_ready",  {63'd0, cmd_ready8}, 64'd1);
    check("rst_req",    {63'd0, mem_req8},   64'd0);
    check("rst_busy",   {63'd0, busy8},      64'd0);
    check("rst_done",   {63'd0, done8},      64'd0);
    check("rst_addr",   {38'd0, mem_addr8},  64'd0);
    check("rst_wdata",  {32'd0, mem_wdata8}, 64'd0);
    check("rst_be",     {60'd0, mem_be8},    64'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;

    // Partial words at both ends of two rows
    set_cmd(26'h1000, 16'd320, 16'd1, 16'd0, 16'd6, 16'd2, 16'd0, 16'd0, 16'd320, 16'd240,
            32'hAB, 32'h0);
    exp8_q.push_back(ex(26'h1000, 4'b1110, 32'hABAB_ABAB));
    exp8_q.push_back(ex(26'h1004, 4'b0011, 32'hABAB_ABAB));
    exp8_q.push_back(ex(26'h1140, 4'b1110, 32'hABAB_ABAB));
    exp8_q.push_back(ex(26'h1144, 4'b0011, 32'hABAB_ABAB));
    send(1'b0);
    check("setup_req",  {63'd0, mem_req8}, 64'd0);
    check("setup_busy", {63'd0, busy8},    64'd1);
    @(posedge clock); #1;
    check("first_req_latency", {63'd0, mem_req8}, 64'd1);
    wait_idle(1'b0);
    check("done_count_t1", 64'(done_cnt8), 64'd1);

    // Clip window trims the rectangle to x 15..17
    set_cmd(26'h0, 16'd64, 16'd10, 16'd10, 16'd20, 16'd20, 16'd15, 16'd0, 16'd18, 16'd240,
            32'h3C, 32'h0);
    for (int k = 10; k < 20; k++) begin
      exp8_q.push_back(ex(26'(64 * k + 12), 4'b1000, 32'h3C3C_3C3C));
      exp8_q.push_back(ex(26'(64 * k + 16), 4'b0011, 32'h3C3C_3C3C));
    end
    send(1'b0);
    wait_idle(1'b0);
    check("done_count_t2", 64'(done_cnt8), 64'd2);

    // Zero-area command, with the next command already waiting behind it
    set_cmd(26'h0, 16'd64, 16'd5, 16'd0, 16'd5, 16'd2, 16'd0, 16'd0, 16'd320, 16'd240,
            32'h77, 32'h0);
    send(1'b0);
    check("zero_ready_setup", {63'd0, cmd_ready8}, 64'd0);
    set_cmd(26'h0, 16'd64, 16'd0, 16'd0, 16'd4, 16'd1, 16'd0, 16'd0, 16'd320, 16'd240,
            32'h11, 32'h22);
    exp8_q.push_back(ex(26'h0, 4'b1111, dith_exp));
    cmd_valid8 = 1'b1;
    @(posedge clock); #1;
    check("zero_done_pulse", {63'd0, done8},      64'd1);
    check("zero_ready_idle", {63'd0, cmd_ready8}, 64'd1);
    check("zero_no_req",     {63'd0, mem_req8},   64'd0);
    @(posedge clock); #1;
    cmd_valid8 = 1'b0;
    check("queued_cmd_taken", {63'd0, busy8}, 64'd1);
    wait_idle(1'b0);
    check("done_count_t3", 64'(done_cnt8), 64'd4);

    // 16-bit pixels
    set_cmd(26'h0, 16'd320, 16'd1, 16'd0, 16'd4, 16'd1, 16'd0, 16'd0, 16'd320, 16'd240,
            32'h1234, 32'h0);
    exp16_q.push_back(ex(26'h0, 4'b1100, 32'h1234_1234));
    exp16_q.push_back(ex(26'h4, 4'b1111, 32'h1234_1234));
    send(1'b1);
    wait_idle(1'b1);
    check("done_count16", 64'(done_cnt16), 64'd1);

    // Stalled request holds, then reset lands mid-rectangle
    stall8 = 1'b1;
    set_cmd(26'h0, 16'd64, 16'd10, 16'd10, 16'd20, 16'd20, 16'd15, 16'd0, 16'd18, 16'd240,
            32'h5A, 32'h0);
    for (int k = 10; k < 20; k++) begin
      exp8_q.push_back(ex(26'(64 * k + 12), 4'b1000, 32'h5A5A_5A5A));
      exp8_q.push_back(ex(26'(64 * k + 16), 4'b0011, 32'h5A5A_5A5A));
    end
    send(1'b0);
    @(posedge clock); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock); #2;
      check("hold_req",  {63'd0, mem_req8},   64'd1);
      check("hold_addr", {38'd0, mem_addr8},  64'd652);
      check("hold_be",   {60'd0, mem_be8},    64'h8);
      check("hold_data", {32'd0, mem_wdata8}, 64'h5A5A_5A5A);
    end
    stall8 = 1'b0;
    repeat (8) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("abort_req",   {63'd0, mem_req8},   64'd0);
    check("abort_busy",  {63'd0, busy8},      64'd0);
    check("abort_ready", {63'd0, cmd_ready8}, 64'd1);
    exp8_q.delete();
    repeat (2) @(negedge clock);
    #3;
    reset = 1'b1;
    @(negedge clock); #2;
    check("post_rst_ready", {63'd0, cmd_ready8}, 64'd1);
    check("post_rst_addr",  {38'd0, mem_addr8},  64'd0);
    check("post_rst_done_count", 64'(done_cnt8), 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/blit_rect_fill.md
Name: blit_rect_fill

Overview:
- Parametrised rectangle-fill engine for the blitter. Generalises the 8-bit-per-pixel single-pixel write path to configurable pixel depth.
- Accepts one fill command per handshake and clips it against a clip window.
- Walks the clipped rectangle row by row, coalescing all pixels that fall in one 32-bit word into a single byte-enabled SDRAM write request.
- Sits between the command FIFO and the SDRAM write arbiter port.

Parameters:
- BPP, 8, pixel depth in bits; legal values 8, 16, 32. PPW = 32/BPP pixels per word.
- ADDR_W, 26, SDRAM byte-address width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command.
- cmd_dest_addr  in  ADDR_W  byte address of pixel (0,0).
- cmd_bpl  in  16  bytes per line.
- cmd_x1, cmd_y1  in  16 each  rectangle start, inclusive, unsigned.
- cmd_x2, cmd_y2  in  16 each  rectangle end, exclusive, unsigned.
- clip_x1, clip_y1, clip_x2, clip_y2  in  16 each  clip window; x1/y1 inclusive, x2/y2 exclusive.
- cmd_color  in  32  fill colour; low BPP bits used.
- cmd_color2  in  32  second colour, dither only.
- mem_req  out  1  write request.
- mem_addr  out  ADDR_W  word-aligned byte address; bits [1:0] always 0.
- mem_wdata  out  32  write data.
- mem_byte_enable  out  4  byte enables; bit0 = bits [7:0] = lowest address.
- mem_ack  in  1  request accepted.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Reset values: state IDLE; cmd_ready=1; mem_req=0; mem_addr, mem_wdata, mem_byte_enable = 0; busy=0; done=0.
- cmd_ready = (state==IDLE). Accept on cmd_valid && cmd_ready; all cmd_* and clip_* are sampled that cycle.
- States:
  - IDLE: waits for a command.
  - SETUP (1 cycle): cx1=max(x1,clip_x1), cx2=min(x2,clip_x2), cy1, cy2 likewise. If cx1>=cx2 or cy1>=cy2, go to IDLE, pulse done, issue no writes. Otherwise row_base = dest + cy1*bpl, x=cx1, y=cy1, then go to WRITE.
  - WRITE: mem_req=1, with mem_addr, mem_wdata and mem_byte_enable held stable until the mem_ack cycle.
    - byte address = row_base + x*(BPP/8); mem_addr is that value with [1:0] cleared.
    - Word pixel span = pixels x .. min(next word boundary, cx2)-1. mem_byte_enable covers exactly those pixels' bytes.
    - mem_wdata = colour replicated PPW times.
  - On mem_ack: x advances to the next word boundary. If x>=cx2, then y++, row_base += bpl, x=cx1. If y==cy2, go to IDLE with done=1 in the same cycle as the return. Otherwise a new request is presented the next cycle, so mem_req deasserts for exactly one cycle between requests.
- Latency: accept at cycle N, SETUP at N+1, first mem_req at N+2.
- Arithmetic: address math is modulo 2^ADDR_W. Rectangle coordinates larger than the clip are silently clipped.
- busy = (state != IDLE). A cmd_valid arriving while busy waits; no overflow or loss.
- An asserted reset aborts immediately: mem_req drops asynchronously and no partial-command state survives.
- BPP=32 always gives byte enable 1111. BPP=16 gives 0011, 1100 or 1111.

Optional Feature:
- Macro: BLIT_RECT_DITHER_EN.
- Defined: a pixel at (x,y) with ((x^y)&1)==1 takes cmd_color2, all others take cmd_color. Pixels are merged per lane in mem_wdata.
- Undefined: cmd_color2 is ignored and all pixels use cmd_color. Ports are identical either way.

Test Plan:
- BPP=8, dest 0x1000, bpl 320, rect (1,0)-(6,2), clip (0,0)-(320,240), colour 0xAB -> exactly 4 writes, then done:
  - 0x1000 be 1110;
  - 0x1004 be 0011;
  - 0x1140 be 1110;
  - 0x1144 be 0011;
  - all with data 0xABABABAB.
- BPP=8, dest 0, bpl 64, rect (10,10)-(20,20), clip (15,0)-(18,240) -> per row k=10..19: two writes, 64k+12 be 1000 then 64k+16 be 0011. 20 writes total.
- Zero area: rect x1=x2=5 -> no mem_req; done at accept+2. A second cmd_valid during that interval sees cmd_ready=0 until IDLE.
- BPP=16, dest 0, rect (1,0)-(4,1), colour 0x1234 -> addr 0 be 1100, then addr 4 be 1111, data 0x12341234.
- Hold mem_ack low for 5 cycles -> mem_req, addr, data and be stay unchanged. Then assert reset mid-rectangle -> mem_req=0 immediately, busy=0, cmd_ready=1 after release.
- BLIT_RECT_DITHER_EN, BPP=8, rect (0,0)-(4,1), colours 0x11/0x22 -> addr 0 be 1111, data 0x22112211. With the macro undefined, the same stimulus gives data 0x11111111.
